wb_merge: RTL and testbench

WB_MERGE -- requirements
Module: wb_merge

---
 rtl/wb_merge.sv | 107 ++++++++++
 tb/tb_wb_merge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_merge.sv
// Register-file writeback merger: in-order pipeline writes take priority and
// out-of-order late results wait in a small FIFO.
module wb_merge #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        late_valid,
  output logic        late_ready,
  input  logic [4:0]  late_addr,
  input  logic [31:0] late_data,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  output logic        WEN,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_d;
  logic [DEPTH-1:0] live, live_d;
  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];

  logic pipe_acc, late_enq, not_empty, head_live, deq;

  assign late_ready = !rst && (count < CW'(DEPTH));
  assign pipe_acc   = !rst && pipe_valid && (pipe_addr != 5'd0);
  // x0 transfers still complete the handshake but never enqueue.
  assign late_enq   = late_valid && late_ready && (late_addr != 5'd0);
  assign not_empty  = (count != '0);
  assign head_live  = not_empty && live[rd_ptr];
  // A live head must yield to a pipe write; a killed head can always pop.
  assign deq        = not_empty && (!pipe_acc || !live[rd_ptr]);
  assign busy       = not_empty;
  assign count_d    = count + CW'(late_enq) - CW'(deq);

  // Kill older entries first so a same-cycle enqueue to the same register stays live.
  always_comb begin
    live_d = live;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_acc && (q_addr[i] == pipe_addr)) live_d[i] = 1'b0;
    end
    if (deq)      live_d[rd_ptr] = 1'b0;
    if (late_enq) live_d[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      live   <= '0;
      WEN    <= 1'b0;
      w_addr <= 5'd0;
      w_data <= 32'd0;
    end else begin
      count <= count_d;
      live  <= live_d;
      if (late_enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq)      rd_ptr <= rd_ptr + PW'(1);
      if (pipe_acc) begin
        WEN    <= 1'b1;
        w_addr <= pipe_addr;
        w_data <= pipe_data;
      end else if (head_live) begin
        WEN    <= 1'b1;
        w_addr <= q_addr[rd_ptr];
        w_data <= q_data[rd_ptr];
      end else begin
        WEN <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by the live bits and count.
  always_ff @(posedge clk) begin
    if (late_enq) begin
      q_addr[wr_ptr] <= late_addr;
      q_data[wr_ptr] <= late_data;
    end
  end

  // Pending check covers live queue entries and the write still in the output register.
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (q_addr[i] == rd_addr1)) pend_hit1 = 1'b1;
      if (live[i] && (q_addr[i] == rd_addr2)) pend_hit2 = 1'b1;
    end
    if (WEN && (w_addr == rd_addr1)) pend_hit1 = 1'b1;
    if (WEN && (w_addr == rd_addr2)) pend_hit2 = 1'b1;
    if (rst || (rd_addr1 == 5'd0)) pend_hit1 = 1'b0;
    if (rst || (rd_addr2 == 5'd0)) pend_hit2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_merge.sv
// Scoreboard bench for wb_merge: expected register-file writes are queued by
// the stimulus and checked by a monitor whenever WEN is high.
module tb_wb_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_addr;
  logic [31:0] late_data;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        WEN;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        pend_hit1, pend_hit2;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q [$];

  wb_merge #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .late_valid (late_valid),
    .late_ready (late_ready),
    .late_addr  (late_addr),
    .late_data  (late_data),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .WEN        (WEN),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .pend_hit1  (pend_hit1),
    .pend_hit2  (pend_hit2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every write seen must match the oldest expected write.
  always @(negedge clk) begin
    if (WEN) begin
      logic [36:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", w_addr, w_data);
      end else begin
        e = exp_q.pop_front();
        if ({w_addr, w_data} !== e) begin
          errors++;
          $display("FAIL write_match: got addr=%0d data=%h, required addr=%0d data=%h",
                   w_addr, w_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid = 1'b0;
    late_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    pipe_valid = 1'b1;
    pipe_addr  = a;
    pipe_data  = d;
  endtask

  task automatic late(input logic [4:0] a, input logic [31:0] d);
    late_valid = 1'b1;
    late_addr  = a;
    late_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    pipe_addr = '0; pipe_data = '0; late_addr = '0; late_data = '0;
    rd_addr1 = 5'd1; rd_addr2 = 5'd2;
    step(); step();
    chk("reset_wen", 32'(WEN), 32'd0);
    chk("reset_waddr", 32'(w_addr), 32'd0);
    chk("reset_wdata", w_data, 32'd0);
    chk("reset_late_ready", 32'(late_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pend", 32'({pend_hit1, pend_hit2}), 32'd0);
    rst = 1'b0;
    #1;
    chk("release_late_ready", 32'(late_ready), 32'd1);

    // Single pipe write, one-cycle latency, then WEN drops.
    pipe(5'd5, 32'h11);
    exp_q.push_back({5'd5, 32'h11});
    step(); idle();
    rd_addr1 = 5'd5;
    #1;
    chk("pend_outreg", 32'(pend_hit1), 32'd1);
    step();
    chk("wen_drop", 32'(WEN), 32'd0);

    // Four late writes stall behind a continuous pipe stream, then drain in order.
    for (int k = 0; k < 4; k++) begin
      pipe(5'd9, 32'h900 + 32'(k));
      late(5'(k + 1), 32'h100 + 32'(k));
      exp_q.push_back({5'd9, 32'h900 + 32'(k)});
      #1;
      chk("late_ready_fill", 32'(late_ready), 32'd1);
      step();
    end
    idle();
    rd_addr1 = 5'd3; rd_addr2 = 5'd20;
    #1;
    chk("late_ready_full", 32'(late_ready), 32'd0);
    chk("busy_full", 32'(busy), 32'd1);
    chk("pend_queue_hit", 32'(pend_hit1), 32'd1);
    chk("pend_queue_miss", 32'(pend_hit2), 32'd0);
    for (int k = 0; k < 4; k++) exp_q.push_back({5'(k + 1), 32'h100 + 32'(k)});
    repeat (4) step();
    chk("busy_drained", 32'(busy), 32'd0);
    step();

    // Newer pipe write kills the queued late result to the same register.
    late(5'd7, 32'hAA);
    step(); idle();
    pipe(5'd7, 32'hBB);
    exp_q.push_back({5'd7, 32'hBB});
    step(); idle();
    chk("busy_killed_entry", 32'(busy), 32'd1);
    rd_addr1 = 5'd7;
    step();
    chk("killed_pop_wen", 32'(WEN), 32'd0);
    chk("killed_pop_busy", 32'(busy), 32'd0);
    chk("killed_pend", 32'(pend_hit1), 32'd0);

    // Same-cycle pipe and late to x3: late is younger and lands second.
    pipe(5'd3, 32'h1);
    late(5'd3, 32'h2);
    exp_q.push_back({5'd3, 32'h1});
    exp_q.push_back({5'd3, 32'h2});
    step(); idle();
    step(); step();
    chk("same_cycle_busy", 32'(busy), 32'd0);

    // x0 requests are dropped but the late handshake completes.
    pipe(5'd0, 32'h55);
    late(5'd0, 32'h66);
    #1;
    chk("x0_late_ready", 32'(late_ready), 32'd1);
    step(); idle();
    chk("x0_busy", 32'(busy), 32'd0);
    chk("x0_wen", 32'(WEN), 32'd0);
    step();
    chk("x0_wen_later", 32'(WEN), 32'd0);

    // Reset mid-operation discards three live queued entries.
    for (int k = 0; k < 3; k++) begin
      pipe(5'd9, 32'hA00 + 32'(k));
      late(5'(10 + k), 32'hC00 + 32'(k));
      exp_q.push_back({5'd9, 32'hA00 + 32'(k)});
      step();
    end
    idle();
    rd_addr1 = 5'd11;
    #1;
    chk("pre_reset_pend", 32'(pend_hit1), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("post_reset_wen", 32'(WEN), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_late_ready", 32'(late_ready), 32'd1);
    chk("post_reset_pend", 32'(pend_hit1), 32'd0);
    repeat (5) step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
